// File: rtl/uart_rx_engine.sv
// uart_rx_engine: UART receive path.
// Deserializes rx into bytes with parity, framing and overrun status.
module uart_rx_engine #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx,
    input  logic [18:0] k,
    input  logic        eight,
    input  logic        pen,
    input  logic        ohel,
    input  logic        clr_rdy,
    output logic [7:0]  rdata,
    output logic        rxrdy,
    output logic        perr,
    output logic        ferr,
    output logic        ovf
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    logic [SYNC_STAGES-1:0] r_sync;
    logic [1:0]             r_state;
    logic [18:0]            r_cnt;
    logic [3:0]             r_bitn;
    logic [8:0]             r_sr;
    logic                   r_eight;
    logic                   r_pen;
    logic                   r_ohel;
    logic                   r_armed;
    logic [7:0]             r_rdata;
    logic                   r_rxrdy;
    logic                   r_perr;
    logic                   r_ferr;
    logic                   r_ovf;

    logic        w_rxs;
    logic [18:0] w_half;
    logic [18:0] w_kend;
    logic        w_half_tc;
    logic        w_bit_tc;
    logic [3:0]  w_nsamp;
    logic        w_last;
    logic [7:0]  w_data;
    logic        w_par;
    logic        w_perr;
    logic        w_capture;

    assign w_rxs     = r_sync[SYNC_STAGES-1];
    assign w_half    = {1'b0, k[18:1]};
    assign w_kend    = k - 19'd1;
    assign w_half_tc = (r_cnt == w_half);
    assign w_bit_tc  = (r_cnt == w_kend);
    assign w_nsamp   = (r_eight ? 4'd8 : 4'd7) + {3'b000, r_pen};
    assign w_last    = (r_bitn == (w_nsamp - 4'd1));
    // Samples are stored by index: data bits first, parity right after.
    assign w_data    = r_eight ? r_sr[7:0] : {1'b0, r_sr[6:0]};
    assign w_par     = r_eight ? r_sr[8] : r_sr[7];
    assign w_perr    = r_pen & (w_par != ((^w_data) ^ r_ohel));
    assign w_capture = (r_state == STOP) && w_bit_tc;

    assign rdata = r_rdata;
    assign rxrdy = r_rxrdy;
    assign perr  = r_perr;
    assign ferr  = r_ferr;
    assign ovf   = r_ovf;

    // Metastability synchronizer for the asynchronous rx line, idles high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], rx};
        end
    end

    // Re-arm gate: after a frame, rx must be seen high before a new start.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_armed <= 1'b0;
        end else if (w_capture) begin
            r_armed <= 1'b0;
        end else if ((r_state == IDLE) && w_rxs) begin
            r_armed <= 1'b1;
        end
    end

    // Bit-time counter: half bit in START, full bit in DATA and STOP.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else begin
            case (r_state)
                IDLE:    r_cnt <= '0;
                START:   r_cnt <= w_half_tc ? 19'd0 : r_cnt + 19'd1;
                default: r_cnt <= w_bit_tc ? 19'd0 : r_cnt + 19'd1;
            endcase
        end
    end

    // Frame sequencer; also latches the frame format and collects samples.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_bitn  <= '0;
            r_sr    <= '0;
            r_eight <= 1'b0;
            r_pen   <= 1'b0;
            r_ohel  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (r_armed && !w_rxs) begin
                        r_state <= START;
                    end
                end
                START: begin
                    if (w_half_tc) begin
                        if (w_rxs) begin
                            r_state <= IDLE;
                        end else begin
                            r_state <= DATA;
                            r_bitn  <= '0;
                            r_eight <= eight;
                            r_pen   <= pen;
                            r_ohel  <= ohel;
                        end
                    end
                end
                DATA: begin
                    if (w_bit_tc) begin
                        r_sr[r_bitn] <= w_rxs;
                        r_bitn       <= r_bitn + 4'd1;
                        if (w_last) begin
                            r_state <= STOP;
                        end
                    end
                end
                default: begin
                    if (w_bit_tc) begin
                        r_state <= IDLE;
                    end
                end
            endcase
        end
    end

    // Result and status registers; a capture takes priority over clr_rdy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rdata <= '0;
            r_rxrdy <= 1'b0;
            r_perr  <= 1'b0;
            r_ferr  <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_capture) begin
            r_rdata <= w_data;
            r_rxrdy <= 1'b1;
            r_perr  <= w_perr;
            r_ferr  <= ~w_rxs;
            r_ovf   <= r_rxrdy & ~clr_rdy;
        end else if (clr_rdy) begin
            r_rxrdy <= 1'b0;
            r_perr  <= 1'b0;
            r_ferr  <= 1'b0;
            r_ovf   <= 1'b0;
        end
    end

endmodule

// File: doc/uart_rx_engine.md
Name: uart_rx_engine

Overview:
Receive engine of the full UART. It deserializes the asynchronous rx line into bytes and sits opposite the transmit load/shift path. It samples mid-bit using the programmable bit-time count, checks parity and stop bit, and presents the byte with a ready flag and status bits to the TSI/processor read path. Status is cleared by a one-cycle read strobe.

Parameters:
SYNC_STAGES, 2, number of rx synchronizer flops (legal values 2 or 3).

Ports:
clk  input  1  100 MHz system clock
reset  input  1  asynchronous, active-high reset
rx  input  1  serial receive line, idle high, asynchronous to clk
k  input  19  clk cycles per bit time; legal range 16..2^19-1; must be stable while a frame is in progress
eight  input  1  1 = 8 data bits; 0 = 7 data bits
pen  input  1  1 = parity bit present
ohel  input  1  parity sense: 1 = odd, 0 = even
clr_rdy  input  1  one-cycle read strobe; clears rxrdy, perr, ferr and ovf
rdata  output  8  received byte; bit 7 forced to 0 in 7-bit mode
rxrdy  output  1  byte available
perr  output  1  parity error on the last captured frame
ferr  output  1  framing error (stop bit sampled 0) on the last captured frame
ovf  output  1  overrun: a new byte was captured while rxrdy was still 1

Behaviour:
- Reset (async assert): every output is 0. The FSM goes to IDLE, the counters clear, and the synchronizer flops preset to 1.
- The rx input passes through SYNC_STAGES flops. All references to "rx" below mean the synchronized rx (rxs).
- FSM states are IDLE, START, DATA, STOP.
- IDLE: the bit-time counter is held at 0. When rxs == 0, go to START.
- START: count to k/2 (integer floor).
  - At terminal count, if rxs == 1, this is a false start: return to IDLE with no flags changed.
  - Otherwise, reset the counter and go to DATA.
- DATA: count to k-1, then sample rxs at the terminal count (mid-bit).
  - Data bits shift right into a shift register, LSB first.
  - Number of samples is N = (eight ? 8 : 7) + pen.
  - When pen = 1, the last sample in DATA is the parity bit.
  - After N samples, go to STOP.
- STOP: count to k-1, then sample the stop bit.
  - Load rdata: 8-bit mode gets sr[7:0]; 7-bit mode gets {1'b0, sr[6:0]}.
  - Set rxrdy = 1.
  - Set ferr = ~stop_sample.
  - Set perr = pen & (parity_sample != expected).
    - Expected parity is (^data) ^ ohel for the active data width, so that with ohel = 1 the total count of ones over data plus parity is odd.
    - When pen = 0, perr is 0.
  - Set ovf = 1 if rxrdy was already 1 at this edge and clr_rdy is not asserted in the same cycle.
  - Return to IDLE in the same edge, i.e. mid-stop-bit, so a start bit that follows immediately is caught.
- Latency: rxrdy rises on the edge k/2 + 1 + N*k + k cycles (±1) after rxs falls. rxs itself lags rx by SYNC_STAGES cycles.
- clr_rdy clears rxrdy, perr, ferr and ovf on the next edge.
  - If clr_rdy coincides with a capture, the capture wins: rxrdy = 1, perr/ferr take the new values, ovf = 0.
  - clr_rdy never alters rdata.
- rdata, perr and ferr hold their values until the next capture or reset.
- A framing-error byte is still delivered with rxrdy = 1.
- A break (rx held low) produces one frame with ferr = 1. After that, no new frame starts until rxs returns high and then falls again: IDLE requires rxs == 1 for at least one cycle after STOP before it may re-arm.
- Reset mid-frame aborts immediately. No partial byte is delivered after reset deasserts.
- Changes to eight, pen or ohel mid-frame are illegal. They are sampled at the START→DATA transition.

Test Plan:
- k = 868, eight = 1, pen = 0. Send 0xA5 8N1 → rdata = 0xA5, rxrdy = 1 about 8246 cycles after the falling edge; perr = ferr = ovf = 0. Pulse clr_rdy → rxrdy = 0 next cycle, rdata remains 0xA5.
- k = 868. Drive rx low for 300 cycles, then high → no rxrdy; FSM back in IDLE. A valid 0x3C frame sent afterwards is received correctly.
- k = 868, eight = 0, pen = 1, ohel = 0.
  - Send 0x41 with parity bit 0 → rdata = 0x41, perr = 0.
  - Resend with parity bit 1 → perr = 1.
  - Repeat with ohel = 1 → the perr results invert.
- k = 868. Send 0x55 with stop bit 0 → rdata = 0x55, rxrdy = 1, ferr = 1.
- Two back-to-back frames, 0x11 then 0x22, with no clr_rdy → after the second: rdata = 0x22, ovf = 1. Then assert clr_rdy exactly on the third frame's capture edge → rxrdy = 1, ovf = 0.
- Assert reset at mid-bit 4 of a 0xFF frame and deassert 10 cycles later → all outputs 0, no rxrdy. The next full 0x81 frame is received correctly.
